axis_fifo: RTL and testbench
============================

// Module: axis_fifo
// PURPOSE
// - Parametrised AXI4-Stream FIFO: buffers full AXIS beats (tdata/tstrb/tkeep/tlast/tid/tdest/tuser) between a slave and a master port.
// - Optional packet mode holds output until a complete packet (tlast) is stored; used ahead of DMA/framers needing whole frames.
// - Provides occupancy and stored-packet counts for flow control and debug.
// PARAMETERS
// - TDATA_BYTES  4  tdata width in bytes; tstrb/tkeep are TDATA_BYTES bits
// - TID_BITS     1  tid width
// - TDEST_BITS   1  tdest width
// - TUSER_BITS   1  tuser width
// - DEPTH        16 beats stored; power of two, >= 2
// - PACKET_MODE  0  0 = cut-through, 1 = store-and-forward
// PORTS
// - aclk           in   1             clock; all logic on rising edge
// - areset         in   1             synchronous, active-high reset
// - s_axis_t*      -    per params    slave beat: tvalid in, tready out, tdata/tstrb/tkeep/tlast/tid/tdest/tuser in
// - m_axis_t*      -    per params    master beat: tvalid out, tready in, tdata/tstrb/tkeep/tlast/tid/tdest/tuser out
// - count          out  CW            beats stored, CW = $clog2(DEPTH+1)
// - pkt_count      out  CW            complete packets (stored tlast beats)
// - full / empty   out  1             count==DEPTH / count==0
// BEHAVIOUR
// - One clock (aclk); reset synchronous, active-high (areset).
// - Reset: pointers, count, pkt_count = 0; m_axis_tvalid=0; s_axis_tready=1 on first cycle after reset; empty=1, full=0; payload outputs 0.
// - Write = s_tvalid & s_tready; read = m_tvalid & m_tready. Beat transfers only on write/read.
// - s_axis_tready = !full; depends only on registered count, never on m_axis_tready (no comb path in->out).
// - Full + read in same cycle: no write accepted that cycle; tready rises next cycle.
// - First-word-fall-through, latency 1: beat written in cycle N visible on m_axis (tvalid=1) in N+1 when empty.
// - Empty + write in same cycle: no read possible; count becomes 1.
// - Non-empty write+read same cycle: count unchanged; both pointers advance.
// - m_axis payload stable while m_tvalid & !m_tready (AXIS rule); tvalid never drops without a read.
// - Pointers log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
// - pkt_count: +1 on write with tlast, -1 on read with tlast, unchanged if both.
// - PACKET_MODE=0: m_tvalid = !empty.
// - PACKET_MODE=1: m_tvalid = !empty & (pkt_count!=0 | full | draining). draining set when a read starts while full and
//   pkt_count==0 (oversize packet release, no deadlock); cleared after the read of a tlast beat.
// - Once a packet begins output in mode 1, it is never stalled by the FIFO (only by m_tready) until its tlast.
// - Reset mid-packet: all stored data discarded, next beat on s_axis treated as packet start.
// - tstrb/tkeep/tid/tdest/tuser carried unmodified; no checking of tkeep/tstrb legality.
// STRUCTURE
// - axis_pkg: localparam helpers (CW calc), typedef struct packed axis_beat_t built from params (via parametrised
//   class/macro), beat pack/unpack functions.
// - Sub-module axis_fifo_ram: simple dual-port memory, DEPTH x beat width, registered read, write-first not required.
// - Top: pointer/count/pkt_count logic, packet-mode gate, FWFT output register.
// TESTING
// - Reset: areset 2 cycles -> s_tready=1, m_tvalid=0, count=0, empty=1, full=0.
// - Mode 0, DEPTH=16: write 16 beats tdata=0..15, m_tready=0 -> full=1, s_tready=0; release -> 0..15 in order, count to 0.
// - Mode 0, streaming: both valid/ready=1 continuously for 100 beats -> 1 beat/cycle, count stays 1, data order preserved.
// - Mode 1: write 5-beat packet, withhold tlast 10 cycles -> m_tvalid=0; send tlast -> m_tvalid=1 next cycle, pkt_count=1.
// - Mode 1 oversize: 20-beat packet into DEPTH=16 -> 16 stored, full=1, draining releases; all 20 beats exit in order.
// - Random valid/ready backpressure, random tid/tdest/tuser/tkeep, areset mid-packet -> scoreboard match, empty after reset.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI4-Stream FIFO: default widths, mode encoding and
// width calculations used by the top and its memory.
package axis_fifo_pkg;

  localparam int DEF_TDATA_BYTES = 4;
  localparam int DEF_TID_BITS    = 1;
  localparam int DEF_TDEST_BITS  = 1;
  localparam int DEF_TUSER_BITS  = 1;
  localparam int DEF_DEPTH       = 16;

  typedef enum logic {
    MODE_CUT_THROUGH   = 1'b0,
    MODE_STORE_FORWARD = 1'b1
  } fifo_mode_e;

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int beatWidth(input int dataBytes, input int idBits,
                                   input int destBits, input int userBits);
    return 8 * dataBytes + 2 * dataBytes + 1 + idBits + destBits + userBits;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat memory with a registered read port; a read of the
// address written on the same edge returns the previous contents.
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_wrEn,
  input  logic [AW-1:0]    i_wrAddr,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic [AW-1:0]    i_rdAddr,
  output logic [WIDTH-1:0] o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    o_rdData <= r_mem[i_rdAddr];
  end

endmodule

// File: rtl/axis_fifo.sv
// AXI4-Stream FIFO with first-word-fall-through output and an optional
// store-and-forward gate that releases beats only once a whole packet is held.
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int TDATA_BYTES = DEF_TDATA_BYTES,
  parameter int TID_BITS    = DEF_TID_BITS,
  parameter int TDEST_BITS  = DEF_TDEST_BITS,
  parameter int TUSER_BITS  = DEF_TUSER_BITS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PACKET_MODE = 0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [8*TDATA_BYTES-1:0]    s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]      s_axis_tstrb,
  input  logic [TDATA_BYTES-1:0]      s_axis_tkeep,
  input  logic                        s_axis_tlast,
  input  logic [TID_BITS-1:0]         s_axis_tid,
  input  logic [TDEST_BITS-1:0]       s_axis_tdest,
  input  logic [TUSER_BITS-1:0]       s_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [8*TDATA_BYTES-1:0]    m_axis_tdata,
  output logic [TDATA_BYTES-1:0]      m_axis_tstrb,
  output logic [TDATA_BYTES-1:0]      m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic [TID_BITS-1:0]         m_axis_tid,
  output logic [TDEST_BITS-1:0]       m_axis_tdest,
  output logic [TUSER_BITS-1:0]       m_axis_tuser,
  output logic [cntWidth(DEPTH)-1:0]  count,
  output logic [cntWidth(DEPTH)-1:0]  pkt_count,
  output logic                        full,
  output logic                        empty
);

  localparam int CW = cntWidth(DEPTH);
  localparam int AW = ptrWidth(DEPTH);
  localparam fifo_mode_e MODE = (PACKET_MODE != 0) ? MODE_STORE_FORWARD : MODE_CUT_THROUGH;

  typedef struct packed {
    logic [8*TDATA_BYTES-1:0] data;
    logic [TDATA_BYTES-1:0]   strb;
    logic [TDATA_BYTES-1:0]   keep;
    logic                     last;
    logic [TID_BITS-1:0]      id;
    logic [TDEST_BITS-1:0]    dest;
    logic [TUSER_BITS-1:0]    user;
  } beat_t;

  logic [AW-1:0]           r_wrPtr, r_rdPtr, w_rdAddrNext;
  logic [CW-1:0]           r_count, r_pktCount;
  logic                    r_draining, r_bypass;
  beat_t                   r_bypassBeat, w_sBeat, w_mBeat;
  logic [$bits(beat_t)-1:0] w_ramRdData;
  logic                    w_full, w_empty, w_mValid;
  logic                    w_write, w_read, w_wrLast, w_rdLast;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_mValid     = !w_empty && ((MODE == MODE_CUT_THROUGH) || (r_pktCount != '0) ||
                                     w_full || r_draining);
  assign w_write      = s_axis_tvalid && !w_full;
  assign w_read       = w_mValid && m_axis_tready;
  assign w_wrLast     = w_write && s_axis_tlast;
  assign w_rdLast     = w_read && w_mBeat.last;
  assign w_rdAddrNext = r_rdPtr + AW'(w_read);

  assign w_sBeat = '{data: s_axis_tdata, strb: s_axis_tstrb, keep: s_axis_tkeep,
                     last: s_axis_tlast, id: s_axis_tid, dest: s_axis_tdest,
                     user: s_axis_tuser};

  // The memory is read at the next head address so the head beat is ready the
  // cycle after it moves; a beat written straight into the head slot bypasses it.
  axis_fifo_ram #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk    (aclk),
    .i_wrEn   (w_write),
    .i_wrAddr (r_wrPtr),
    .i_wrData (w_sBeat),
    .i_rdAddr (w_rdAddrNext),
    .o_rdData (w_ramRdData)
  );

  assign w_mBeat = r_bypass ? r_bypassBeat : beat_t'(w_ramRdData);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_pktCount   <= '0;
      r_draining   <= 1'b0;
      r_bypass     <= 1'b1;
      r_bypassBeat <= '0;
    end else begin
      if (w_write) r_wrPtr <= r_wrPtr + AW'(1);
      r_rdPtr <= w_rdAddrNext;

      if (w_write && !w_read)      r_count <= r_count + CW'(1);
      else if (!w_write && w_read) r_count <= r_count - CW'(1);

      if (w_wrLast && !w_rdLast)      r_pktCount <= r_pktCount + CW'(1);
      else if (!w_wrLast && w_rdLast) r_pktCount <= r_pktCount - CW'(1);

      // An oversize packet filling the FIFO is released and kept flowing to its end.
      if (w_rdLast)                                        r_draining <= 1'b0;
      else if (w_read && w_full && (r_pktCount == '0))     r_draining <= 1'b1;

      if (w_write) begin
        r_bypass     <= (r_wrPtr == w_rdAddrNext);
        r_bypassBeat <= w_sBeat;
      end else if (!w_empty) begin
        r_bypass     <= 1'b0;
      end
    end
  end

  assign s_axis_tready = !w_full;
  assign m_axis_tvalid = w_mValid;
  assign m_axis_tdata  = w_mBeat.data;
  assign m_axis_tstrb  = w_mBeat.strb;
  assign m_axis_tkeep  = w_mBeat.keep;
  assign m_axis_tlast  = w_mBeat.last;
  assign m_axis_tid    = w_mBeat.id;
  assign m_axis_tdest  = w_mBeat.dest;
  assign m_axis_tuser  = w_mBeat.user;
  assign count         = r_count;
  assign pkt_count     = r_pktCount;
  assign full          = w_full;
  assign empty         = w_empty;

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: one cut-through and one store-and-forward
// instance share the same stimulus; each step checks the instance it targets.
module tb_axis_fifo;

  logic        aclk;
  logic        areset;
  logic        sValid, sLast, sId, sDest, sUser, mReady;
  logic [31:0] sData;
  logic [3:0]  sStrb, sKeep;

  logic        s0Ready, m0Valid, m0Last, m0Id, m0Dest, m0User, full0, empty0;
  logic [31:0] m0Data;
  logic [3:0]  m0Strb, m0Keep;
  logic [4:0]  count0, pkt0;

  logic        s1Ready, m1Valid, m1Last, m1Id, m1Dest, m1User, full1, empty1;
  logic [31:0] m1Data;
  logic [3:0]  m1Strb, m1Keep;
  logic [4:0]  count1, pkt1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [11:0] side;
  } exp_t;

  exp_t sbQ[$];
  int   srcIdx, srcTotal, pktLen, sinkCnt;
  logic held;
  logic sel;

  logic        selReady, selValid;
  logic [31:0] selData;
  logic [11:0] selSide;

  assign selReady = sel ? s1Ready : s0Ready;
  assign selValid = sel ? m1Valid : m0Valid;
  assign selData  = sel ? m1Data  : m0Data;
  assign selSide  = sel ? {m1Strb, m1Keep, m1Last, m1Id, m1Dest, m1User}
                        : {m0Strb, m0Keep, m0Last, m0Id, m0Dest, m0User};

  axis_fifo #(
    .TDATA_BYTES(4), .TID_BITS(1), .TDEST_BITS(1), .TUSER_BITS(1),
    .DEPTH(16), .PACKET_MODE(0)
  ) u_dut0 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(sValid), .s_axis_tready(s0Ready), .s_axis_tdata(sData),
    .s_axis_tstrb(sStrb), .s_axis_tkeep(sKeep), .s_axis_tlast(sLast),
    .s_axis_tid(sId), .s_axis_tdest(sDest), .s_axis_tuser(sUser),
    .m_axis_tvalid(m0Valid), .m_axis_tready(mReady), .m_axis_tdata(m0Data),
    .m_axis_tstrb(m0Strb), .m_axis_tkeep(m0Keep), .m_axis_tlast(m0Last),
    .m_axis_tid(m0Id), .m_axis_tdest(m0Dest), .m_axis_tuser(m0User),
    .count(count0), .pkt_count(pkt0), .full(full0), .empty(empty0)
  );

  axis_fifo #(
    .TDATA_BYTES(4), .TID_BITS(1), .TDEST_BITS(1), .TUSER_BITS(1),
    .DEPTH(16), .PACKET_MODE(1)
  ) u_dut1 (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(sValid), .s_axis_tready(s1Ready), .s_axis_tdata(sData),
    .s_axis_tstrb(sStrb), .s_axis_tkeep(sKeep), .s_axis_tlast(sLast),
    .s_axis_tid(sId), .s_axis_tdest(sDest), .s_axis_tuser(sUser),
    .m_axis_tvalid(m1Valid), .m_axis_tready(mReady), .m_axis_tdata(m1Data),
    .m_axis_tstrb(m1Strb), .m_axis_tkeep(m1Keep), .m_axis_tlast(m1Last),
    .m_axis_tid(m1Id), .m_axis_tdest(m1Dest), .m_axis_tuser(m1User),
    .count(count1), .pkt_count(pkt1), .full(full1), .empty(empty1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last);
    sValid = valid;
    sData  = data;
    sLast  = last;
    sStrb  = 4'hF;
    sKeep  = 4'hF;
    sId    = 1'b0;
    sDest  = 1'b0;
    sUser  = 1'b0;
  endtask

  task automatic applyReset();
    areset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    mReady = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    sbQ.delete();
    srcIdx  = 0;
    sinkCnt = 0;
    held    = 1'b0;
  endtask

  // One cycle per iteration: check any beat read at the coming edge against
  // the scoreboard, then record any beat the selected FIFO accepts.
  task automatic runCycles(input int n, input int validPct, input int readyPct);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      if (!held) sValid = 1'b0;
      if (!held && srcIdx < srcTotal && $urandom_range(99, 0) < validPct) begin
        sValid = 1'b1;
        sData  = 32'hC000_0000 | 32'(srcIdx);
        sStrb  = 4'($urandom);
        sKeep  = 4'($urandom);
        sId    = 1'($urandom);
        sDest  = 1'($urandom);
        sUser  = 1'($urandom);
        sLast  = ((srcIdx % pktLen) == pktLen - 1);
        held   = 1'b1;
      end
      mReady = ($urandom_range(99, 0) < readyPct);
      if (selValid && mReady) begin
        checkOutput("sb_pending", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("sb_data", selData, e.data);
          checkOutput("sb_side", 32'(selSide), 32'(e.side));
        end
        sinkCnt++;
      end
      if (held && selReady) begin
        sbQ.push_back('{data: sData, side: {sStrb, sKeep, sLast, sId, sDest, sUser}});
        srcIdx++;
        held = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    sel = 1'b0;
    srcTotal = 0;
    pktLen = 1;
    applyReset();

    checkOutput("rst_tready0", 32'(s0Ready), 32'd1);
    checkOutput("rst_tvalid0", 32'(m0Valid), 32'd0);
    checkOutput("rst_count0", 32'(count0), 32'd0);
    checkOutput("rst_pkt0", 32'(pkt0), 32'd0);
    checkOutput("rst_empty0", 32'(empty0), 32'd1);
    checkOutput("rst_full0", 32'(full0), 32'd0);
    checkOutput("rst_data0", m0Data, 32'd0);
    checkOutput("rst_tready1", 32'(s1Ready), 32'd1);
    checkOutput("rst_tvalid1", 32'(m1Valid), 32'd0);
    checkOutput("rst_empty1", 32'(empty1), 32'd1);

    // Fill to DEPTH with the sink stalled.
    mReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      tick();
      if (i == 0) begin
        checkOutput("fwft_valid", 32'(m0Valid), 32'd1);
        checkOutput("fwft_data", m0Data, 32'd0);
        checkOutput("fwft_count", 32'(count0), 32'd1);
      end
    end
    checkOutput("fill_count", 32'(count0), 32'd16);
    checkOutput("fill_full", 32'(full0), 32'd1);
    checkOutput("fill_tready", 32'(s0Ready), 32'd0);
    checkOutput("fill_empty", 32'(empty0), 32'd0);
    checkOutput("pm_full_valid", 32'(m1Valid), 32'd1);

    applyStimulus(1'b1, 32'h99, 1'b0);
    tick();
    checkOutput("full_hold_count", 32'(count0), 32'd16);
    checkOutput("stall_data", m0Data, 32'd0);

    // Drain; the first cycle also offers a beat that must be refused.
    mReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_valid", 32'(m0Valid), 32'd1);
      checkOutput("drain_data", m0Data, 32'(i));
      checkOutput("pm_drain_data", m1Data, 32'(i));
      tick();
      if (i == 0) begin
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("full_rd_count", 32'(count0), 32'd15);
        checkOutput("full_rd_tready", 32'(s0Ready), 32'd1);
      end
    end
    checkOutput("drain_count", 32'(count0), 32'd0);
    checkOutput("drain_empty", 32'(empty0), 32'd1);
    checkOutput("drain_tvalid", 32'(m0Valid), 32'd0);

    // Continuous streaming through the pointer wrap.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0);
      tick();
      checkOutput("stream_count", 32'(count0), 32'd1);
      checkOutput("stream_valid", 32'(m0Valid), 32'd1);
      checkOutput("stream_data", m0Data, 32'h200 + 32'(i));
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("stream_end_count", 32'(count0), 32'd0);

    // Store-and-forward: output held until tlast arrives.
    applyReset();
    mReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h10 + 32'(i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("pm_hold_valid", 32'(m1Valid), 32'd0);
      tick();
    end
    checkOutput("pm_hold_count", 32'(count1), 32'd4);
    checkOutput("pm_hold_pkt", 32'(pkt1), 32'd0);
    applyStimulus(1'b1, 32'h14, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pm_rel_valid", 32'(m1Valid), 32'd1);
    checkOutput("pm_rel_pkt", 32'(pkt1), 32'd1);
    checkOutput("pm_rel_count", 32'(count1), 32'd5);
    checkOutput("ct_pkt", 32'(pkt0), 32'd1);
    for (int j = 0; j < 5; j++) begin
      checkOutput("pm_out_valid", 32'(m1Valid), 32'd1);
      checkOutput("pm_out_data", m1Data, 32'h10 + 32'(j));
      checkOutput("pm_out_last", 32'(m1Last), (j == 4) ? 32'd1 : 32'd0);
      tick();
    end
    checkOutput("pm_done_pkt", 32'(pkt1), 32'd0);
    checkOutput("pm_done_empty", 32'(empty1), 32'd1);
    checkOutput("ct_done_pkt", 32'(pkt0), 32'd0);

    // Oversize packet: 20 beats through a 16-deep store-and-forward FIFO.
    applyReset();
    sel = 1'b1;
    srcTotal = 20;
    pktLen = 20;
    runCycles(20, 100, 0);
    checkOutput("ovr_full", 32'(full1), 32'd1);
    checkOutput("ovr_count", 32'(count1), 32'd16);
    checkOutput("ovr_valid", 32'(m1Valid), 32'd1);
    checkOutput("ovr_pkt", 32'(pkt1), 32'd0);
    checkOutput("ovr_tready", 32'(s1Ready), 32'd0);
    runCycles(40, 100, 100);
    checkOutput("ovr_beats", 32'(sinkCnt), 32'd20);
    checkOutput("ovr_empty", 32'(empty1), 32'd1);
    checkOutput("ovr_pkt_end", 32'(pkt1), 32'd0);

    // Random backpressure, cut-through.
    applyReset();
    sel = 1'b0;
    srcTotal = 150;
    pktLen = 7;
    runCycles(500, 70, 60);
    checkOutput("rnd0_beats", 32'(sinkCnt), 32'd150);
    checkOutput("rnd0_empty", 32'(empty0), 32'd1);

    // Random backpressure, store-and-forward, reset in mid-stream.
    applyReset();
    sel = 1'b1;
    srcTotal = 100;
    pktLen = 6;
    runCycles(40, 80, 50);
    applyReset();
    checkOutput("midrst_empty", 32'(empty1), 32'd1);
    checkOutput("midrst_count", 32'(count1), 32'd0);
    checkOutput("midrst_pkt", 32'(pkt1), 32'd0);
    checkOutput("midrst_valid", 32'(m1Valid), 32'd0);
    checkOutput("midrst_tready", 32'(s1Ready), 32'd1);
    srcTotal = 12;
    pktLen = 4;
    runCycles(200, 80, 60);
    checkOutput("rnd1_beats", 32'(sinkCnt), 32'd12);
    checkOutput("rnd1_empty", 32'(empty1), 32'd1);
    checkOutput("rnd1_pkt", 32'(pkt1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
